mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-access stage directly downstream of the execute-stage ALU.
- Consumes the ALU result: it is the effective address for loads/stores and the pass-through result for all other ops.
- Drives a single-outstanding request/acknowledge data bus, with byte-lane alignment, byte enables and load sign/zero extension.
- Presents a registered writeback record to the register-file write stage.

Parameters:
- XLEN, 32, datapath width; must match core_general.vh. Bus data fixed at 32 bits.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- exec_valid  in  1  execute stage presents an op
- exec_ready  out  1  unit can accept an op this cycle
- aluout  in  XLEN  ALU result / effective address
- rs2data  in  XLEN  store data
- mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- funct3  in  3  access size/sign, RISC-V encoding
- rd_addr  in  5  destination register
- dbus_req  out  1  bus request, held until ack
- dbus_we  out  1  1 = store
- dbus_addr  out  XLEN  word-aligned address ({aluout[XLEN-1:2],2'b00})
- dbus_wdata  out  32  lane-replicated store data
- dbus_be  out  4  byte enables
- dbus_ack  in  1  bus completes request this cycle
- dbus_rdata  in  32  read data, valid with ack
- wb_valid  out  1  one-cycle writeback/retire pulse
- wb_we  out  1  register write enable
- wb_rd  out  5  destination register
- wb_data  out  XLEN  writeback value
- mem_exc  out  1  one-cycle misaligned/illegal-access pulse

Behaviour:
- Reset (rst=1 at a clk edge):
  - State returns to IDLE.
  - All outputs are 0 except exec_ready, which is 1.
  - Any in-flight request is abandoned: dbus_req falls at the same edge, and a later dbus_ack seen in IDLE is ignored.
- States:
  - IDLE: exec_ready=1.
  - BUS: request outstanding.
  - WB: writeback pulse.
- Accept condition: exec_valid & exec_ready. Operands, mem_op, funct3 and rd_addr are captured at the accept edge.
- Non-memory op: IDLE -> WB. wb_valid=1 in the next cycle with wb_data=aluout and wb_we=(rd!=0). Latency 1; throughput 1 op per 2 cycles.
- Load/store alignment checks:
  - Byte ops: always legal.
  - Half-word ops: require addr[0]=0.
  - Word ops: require addr[1:0]=00.
  - funct3 codes 011, 110, 111 (and 100/101 on stores) are illegal.
- Misaligned or illegal access:
  - IDLE -> WB with no bus access.
  - mem_exc=1 and wb_valid=1 with wb_we=0, both for one cycle.
- Legal access: IDLE -> BUS.
  - dbus_req=1 from the cycle after accept.
  - dbus_req, address, data, be and we are stable until the cycle in which dbus_ack=1.
  - On ack -> WB, and dbus_req=0 in the next cycle.
  - Ack in the first request cycle is legal (minimum latency: accept + 2 cycles to wb_valid).
  - No timeout.
- Store lane formatting:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, be=addr[1] ? 1100 : 0011.
  - SW: wdata=rs2, be=1111.
- Store completion: in WB, wb_valid=1 and wb_we=0.
- Load extraction:
  - Lane = dbus_rdata >> (addr[1:0]*8).
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend; LW passes through.
  - Result is registered on the ack edge.
  - wb_we=(rd!=0).
- WB lasts exactly one cycle, then -> IDLE. exec_ready is 0 in BUS and WB, so back-to-back accepts are impossible.
- dbus_ack outside BUS is ignored.
- wb_data holds its last value while wb_valid=0.

Decomposition:
- core_general.vh holds:
  - MEMOP_NONE/LOAD/STORE codes
  - funct3 codes LB, LH, LW, LBU, LHU, SB, SH, SW
  - state encoding (2-bit)
- Sub-module load_align (combinational): inputs rdata, addr[1:0], funct3; output XLEN extended load value.
- Store formatting and the FSM stay in mem_access_unit.

Test Plan:
- Non-memory op: ALU op aluout=0x12345678, rd=5 -> wb_valid next cycle, wb_data=0x12345678, wb_we=1. Same op with rd=0 -> wb_we=0.
- SB: addr 0x103, rs2=0xAABBCCDD -> dbus_addr=0x100, be=1000, wdata=0xDDDDDDDD. Bus acks after 3 wait cycles -> req held 4 cycles, then wb_valid with wb_we=0.
- LB and LBU: addr 0x202, rdata=0x00F00000, ack in first req cycle -> LB wb_data=0xFFFFFFF0, LBU wb_data=0x000000F0, wb_valid 2 cycles after accept.
- Faulting accesses: LW at 0x101 and LH at 0x103 -> mem_exc pulse, dbus_req never rises, wb_we=0. funct3=011 load -> same response.
- Reset during BUS: rst during a store wait -> dbus_req=0 after that edge, exec_ready=1, no wb_valid. A stale ack afterwards -> no effect.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-access stage: bus op codes, RISC-V
// load/store size codes, FSM state encoding and the alignment rule.
package mem_access_unit_pkg;

    localparam logic [1:0] MEMOP_NONE  = 2'b00;
    localparam logic [1:0] MEMOP_LOAD  = 2'b01;
    localparam logic [1:0] MEMOP_STORE = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    // Legal when the size code exists for this direction and the address
    // is naturally aligned for that size. Unsigned variants exist only for loads.
    function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                       input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = ~a[0];
            F3_LW:   ok = (a == 2'b00);
            F3_LBU:  ok = ~is_store;
            F3_LHU:  ok = ~is_store & ~a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load lane extraction with sign/zero extension.
module load_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] load_val
);

    logic [31:0]       lane;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    // Shift the addressed byte lane down to bit 0, then extend by size code.
    always_comb begin
        lane   = rdata >> {addr, 3'b000};
        lane_b = lane[7:0];
        lane_h = lane[15:0];
        case (funct3)
            F3_LB:   load_val = XLEN'(lane_b);
            F3_LH:   load_val = XLEN'(lane_h);
            F3_LBU:  load_val = XLEN'(lane[7:0]);
            F3_LHU:  load_val = XLEN'(lane[15:0]);
            default: load_val = XLEN'(lane);
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: accepts one op at a time from execute, runs a single
// outstanding bus transaction for loads/stores and emits a registered
// writeback record. All outputs come straight from flops.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exec_valid,
    output logic            exec_ready,
    input  logic [XLEN-1:0] aluout,
    input  logic [XLEN-1:0] rs2data,
    input  logic [1:0]      mem_op,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd_addr,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [31:0]     dbus_wdata,
    output logic [3:0]      dbus_be,
    input  logic            dbus_ack,
    input  logic [31:0]     dbus_rdata,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            mem_exc
);

    state_e          state_q, state_d;
    logic            exec_ready_q, exec_ready_d;
    logic            dbus_req_q, dbus_req_d;
    logic            dbus_we_q, dbus_we_d;
    logic [XLEN-1:0] dbus_addr_q, dbus_addr_d;
    logic [31:0]     dbus_wdata_q, dbus_wdata_d;
    logic [3:0]      dbus_be_q, dbus_be_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            mem_exc_q, mem_exc_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] load_val;
    logic            is_load, is_store;

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata    (dbus_rdata),
        .addr     (addr_lo_q),
        .funct3   (funct3_q),
        .load_val (load_val)
    );

    // Next-state and next-output computation for the IDLE/BUS/WB sequence.
    always_comb begin
        state_d      = state_q;
        exec_ready_d = exec_ready_q;
        dbus_req_d   = dbus_req_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_wdata_d = dbus_wdata_q;
        dbus_be_d    = dbus_be_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = wb_we_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        mem_exc_d    = 1'b0;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        rd_d         = rd_q;
        is_load      = (mem_op == MEMOP_LOAD);
        is_store     = (mem_op == MEMOP_STORE);

        case (state_q)
            ST_IDLE: begin
                if (exec_valid && exec_ready_q) begin
                    funct3_d     = funct3;
                    addr_lo_d    = aluout[1:0];
                    rd_d         = rd_addr;
                    wb_rd_d      = rd_addr;
                    exec_ready_d = 1'b0;
                    if (!is_load && !is_store) begin
                        state_d    = ST_WB;
                        wb_valid_d = 1'b1;
                        wb_we_d    = (rd_addr != 5'd0);
                        wb_data_d  = aluout;
                    end else if (!access_ok(is_store, funct3, aluout[1:0])) begin
                        // Faults retire without touching the bus or the register file.
                        state_d    = ST_WB;
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        mem_exc_d  = 1'b1;
                    end else begin
                        state_d      = ST_BUS;
                        dbus_req_d   = 1'b1;
                        dbus_we_d    = is_store;
                        dbus_addr_d  = {aluout[XLEN-1:2], 2'b00};
                        dbus_be_d    = lane_be(funct3, aluout[1:0]);
                        dbus_wdata_d = is_store ? lane_wdata(funct3, rs2data[31:0]) : 32'd0;
                    end
                end
            end
            ST_BUS: begin
                // Request fields stay frozen until the ack cycle.
                if (dbus_ack) begin
                    state_d    = ST_WB;
                    dbus_req_d = 1'b0;
                    wb_valid_d = 1'b1;
                    if (dbus_we_q) begin
                        wb_we_d = 1'b0;
                    end else begin
                        wb_we_d   = (rd_q != 5'd0);
                        wb_data_d = load_val;
                    end
                end
            end
            ST_WB: begin
                state_d      = ST_IDLE;
                exec_ready_d = 1'b1;
                wb_we_d      = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                exec_ready_d = 1'b1;
                dbus_req_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            exec_ready_q <= 1'b1;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_wdata_q <= '0;
            dbus_be_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            mem_exc_q    <= 1'b0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            rd_q         <= '0;
        end else begin
            state_q      <= state_d;
            exec_ready_q <= exec_ready_d;
            dbus_req_q   <= dbus_req_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_wdata_q <= dbus_wdata_d;
            dbus_be_q    <= dbus_be_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            mem_exc_q    <= mem_exc_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            rd_q         <= rd_d;
        end
    end

    assign exec_ready = exec_ready_q;
    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_wdata = dbus_wdata_q;
    assign dbus_be    = dbus_be_q;
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign mem_exc    = mem_exc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: writeback records are predicted into a queue at
// issue time and popped by a negedge monitor whenever wb_valid fires.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exec_valid = 1'b0;
    logic        exec_ready;
    logic [31:0] aluout = '0;
    logic [31:0] rs2data = '0;
    logic [1:0]  mem_op = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd_addr = '0;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack = 1'b0;
    logic [31:0] dbus_rdata = '0;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_exc;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
    } wb_rec_t;

    wb_rec_t     sb[$];
    wb_rec_t     mon_e;
    logic [31:0] last_data;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .exec_valid(exec_valid), .exec_ready(exec_ready),
        .aluout(aluout), .rs2data(rs2data), .mem_op(mem_op), .funct3(funct3),
        .rd_addr(rd_addr), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .wb_valid(wb_valid),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mem_exc(mem_exc)
    );

    // Scoreboard monitor: every writeback pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: wb_valid with empty scoreboard (data %h)", wb_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (wb_we !== mon_e.we || wb_data !== mon_e.data || mem_exc !== mon_e.exc ||
                        (mon_e.we && wb_rd !== mon_e.rd)) begin
                        errors++;
                        $display("FAIL wb_record: got we=%b rd=%0d data=%h exc=%b, want we=%b rd=%0d data=%h exc=%b",
                                 wb_we, wb_rd, wb_data, mem_exc, mon_e.we, mon_e.rd, mon_e.data, mon_e.exc);
                    end
                end
            end else if (mem_exc) begin
                checks++;
                errors++;
                $display("FAIL exc_without_wb: mem_exc=1 while wb_valid=0");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [4:0] rd, input logic [31:0] data, input logic exc);
        wb_rec_t r;
        r.we = we; r.rd = rd; r.data = data; r.exc = exc;
        sb.push_back(r);
        last_data = data;
    endtask

    // Present one op for exactly one accept edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd);
        checks++;
        if (exec_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: exec_ready=%b, want 1", exec_ready);
        end
        exec_valid = 1'b1; mem_op = op; funct3 = f3; aluout = a; rs2data = d; rd_addr = rd;
        step();
        exec_valid = 1'b0; mem_op = 2'b00; aluout = 32'hDEAD_0000; rs2data = 32'h0BAD_0BAD;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({exec_ready, dbus_req, dbus_we, wb_valid, wb_we, mem_exc} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 100000",
                     {exec_ready, dbus_req, dbus_we, wb_valid, wb_we, mem_exc});
        end
        checks++;
        if ({dbus_addr, dbus_wdata, dbus_be, wb_rd, wb_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h be=%b rd=%0d data=%h, want all 0",
                     dbus_addr, dbus_wdata, dbus_be, wb_rd, wb_data);
        end
        rst = 1'b0;
        last_data = 32'd0;
    endtask

    task automatic test_nonmem(input logic [31:0] a, input logic [4:0] rd, input logic [1:0] op);
        push(rd != 5'd0, rd, a, 1'b0);
        issue(op, 3'b010, a, 32'h5555_5555, rd);
        checks++;
        if ({wb_valid, exec_ready, dbus_req} !== 3'b100) begin
            errors++;
            $display("FAIL nonmem_lat1: valid/ready/req=%b, want 100", {wb_valid, exec_ready, dbus_req});
        end
        step();
        checks++;
        if ({wb_valid, exec_ready} !== 2'b01) begin
            errors++;
            $display("FAIL nonmem_return: valid/ready=%b, want 01", {wb_valid, exec_ready});
        end
    endtask

    task automatic test_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_be, input int waits);
        push(1'b0, 5'd9, last_data, 1'b0);
        issue(2'b10, f3, a, d, 5'd9);
        for (int i = 0; i <= waits; i++) begin
            checks++;
            if (dbus_req !== 1'b1 || dbus_we !== 1'b1 || dbus_addr !== {a[31:2], 2'b00} ||
                dbus_be !== exp_be || dbus_wdata !== exp_wdata || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL store_req[%0d]: req=%b we=%b addr=%h be=%b wdata=%h wbv=%b, want 1 1 %h %b %h 0",
                         i, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, wb_valid,
                         {a[31:2], 2'b00}, exp_be, exp_wdata);
            end
            if (i == waits) dbus_ack = 1'b1;
            step();
            dbus_ack = 1'b0;
        end
        checks++;
        if ({dbus_req, wb_valid, exec_ready} !== 3'b010) begin
            errors++;
            $display("FAIL store_done: req/wbv/ready=%b, want 010", {dbus_req, wb_valid, exec_ready});
        end
        step();
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata,
                             input logic [4:0] rd, input logic [31:0] exp);
        push(rd != 5'd0, rd, exp, 1'b0);
        issue(2'b01, f3, a, 32'h0, rd);
        checks++;
        if (dbus_req !== 1'b1 || dbus_we !== 1'b0 || dbus_addr !== {a[31:2], 2'b00}) begin
            errors++;
            $display("FAIL load_req: req=%b we=%b addr=%h, want 1 0 %h",
                     dbus_req, dbus_we, dbus_addr, {a[31:2], 2'b00});
        end
        dbus_ack = 1'b1; dbus_rdata = rdata;
        step();
        dbus_ack = 1'b0; dbus_rdata = 32'h0;
        checks++;
        if ({wb_valid, dbus_req} !== 2'b10) begin
            errors++;
            $display("FAIL load_lat2: wbv/req=%b, want 10", {wb_valid, dbus_req});
        end
        step();
    endtask

    task automatic test_fault(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a);
        push(1'b0, 5'd3, last_data, 1'b1);
        issue(op, f3, a, 32'h1111_2222, 5'd3);
        checks++;
        if ({mem_exc, wb_valid, wb_we, dbus_req} !== 4'b1100) begin
            errors++;
            $display("FAIL fault_pulse op=%b f3=%b a=%h: exc/wbv/we/req=%b, want 1100",
                     op, f3, a, {mem_exc, wb_valid, wb_we, dbus_req});
        end
        step();
        checks++;
        if ({mem_exc, wb_valid, dbus_req, exec_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL fault_end: exc/wbv/req/ready=%b, want 0001",
                     {mem_exc, wb_valid, dbus_req, exec_ready});
        end
    endtask

    task automatic test_reset_in_bus();
        issue(2'b10, 3'b010, 32'h300, 32'hCAFE_F00D, 5'd4);
        step();
        checks++;
        if (dbus_req !== 1'b1) begin
            errors++;
            $display("FAIL rstbus_wait: dbus_req=%b, want 1", dbus_req);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({dbus_req, exec_ready, wb_valid} !== 3'b010) begin
            errors++;
            $display("FAIL rstbus_abandon: req/ready/wbv=%b, want 010", {dbus_req, exec_ready, wb_valid});
        end
        last_data = 32'd0;
        dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
        step();
        dbus_ack = 1'b0;
        checks++;
        if ({dbus_req, exec_ready, wb_valid, mem_exc} !== 4'b0100) begin
            errors++;
            $display("FAIL rstbus_stale_ack: req/ready/wbv/exc=%b, want 0100",
                     {dbus_req, exec_ready, wb_valid, mem_exc});
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        push(1'b1, 5'd1, 32'h0000_0A0A, 1'b0);
        push(1'b1, 5'd1, 32'h0000_0A0A, 1'b0);
        exec_valid = 1'b1; mem_op = 2'b00; aluout = 32'h0000_0A0A; rd_addr = 5'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (wb_valid) pulses++;
        end
        exec_valid = 1'b0;
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL back_to_back: %0d wb pulses in 4 cycles, want 2", pulses);
        end
    endtask

    initial begin
        last_data = 32'd0;
        test_reset();
        test_nonmem(32'h1234_5678, 5'd5, 2'b00);
        test_nonmem(32'h1234_5678, 5'd0, 2'b00);
        test_nonmem(32'h8765_4321, 5'd31, 2'b11);
        test_store(3'b000, 32'h103, 32'hAABB_CCDD, 32'hDDDD_DDDD, 4'b1000, 3);
        test_store(3'b001, 32'h102, 32'h1234_ABCD, 32'hABCD_ABCD, 4'b1100, 0);
        test_store(3'b010, 32'h104, 32'h1234_ABCD, 32'h1234_ABCD, 4'b1111, 1);
        test_load(3'b000, 32'h202, 32'h00F0_0000, 5'd7, 32'hFFFF_FFF0);
        test_load(3'b100, 32'h202, 32'h00F0_0000, 5'd7, 32'h0000_00F0);
        test_load(3'b000, 32'h201, 32'h0000_8000, 5'd8, 32'hFFFF_FF80);
        test_load(3'b001, 32'h202, 32'h8001_7777, 5'd10, 32'hFFFF_8001);
        test_load(3'b101, 32'h202, 32'h8001_7777, 5'd10, 32'h0000_8001);
        test_load(3'b010, 32'h200, 32'h89AB_CDEF, 5'd0, 32'h89AB_CDEF);
        test_fault(2'b01, 3'b010, 32'h101);
        test_fault(2'b01, 3'b001, 32'h103);
        test_fault(2'b01, 3'b011, 32'h100);
        test_fault(2'b10, 3'b100, 32'h100);
        test_fault(2'b10, 3'b010, 32'h102);
        test_reset_in_bus();
        test_back_to_back();
        step(); step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d predicted writebacks never seen, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
